// File: rtl/lycalo_sum_trig_pkg.sv
// Shared definitions for the calorimeter sum trigger.
//   trig_state_t : trigger FSM state encoding
//   DEF_*        : default parameter values
//   log2_ceil    : ceiling log2, used to size the adder tree
package lycalo_sum_trig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_DEAD = 2'd2
    } trig_state_t;

    localparam int DEF_N_CH     = 16;
    localparam int DEF_W_IN     = 25;
    localparam int DEF_N_CONSEC = 1;
    localparam int DEF_DEADTIME = 8;

    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/lycalo_adder_tree.sv
// Fully pipelined signed adder tree with a valid sideband.
//   clk, rst   : clock, async active-high reset
//   data_in    : N_CH packed signed samples, channel i at [W_IN*i +: W_IN]
//   valid_in   : data_in is a new sample set
//   sum        : exact signed sum, LOG2 cycles after valid_in; held between valids
//   valid_out  : sum is new this cycle
// Nodes are stored heap-style: node k sums children 2k and 2k+1; indices
// N_CH..2*N_CH-1 are the (unregistered) leaves, node 1 is the root.
module lycalo_adder_tree
    import lycalo_sum_trig_pkg::*;
#(
    parameter  int N_CH  = DEF_N_CH,
    parameter  int W_IN  = DEF_W_IN,
    localparam int LOG2  = log2_ceil(N_CH),
    localparam int W_SUM = W_IN + LOG2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH*W_IN-1:0]    data_in,
    input  logic                    valid_in,
    output logic signed [W_SUM-1:0] sum,
    output logic                    valid_out
);

    logic signed [W_SUM-1:0] node [1:N_CH-1];
    logic signed [W_SUM-1:0] tree [2:2*N_CH-1];
    logic [LOG2-1:0]         vpipe;
    logic [LOG2-1:0]         stage_en;
    logic [N_CH-1:1]         node_en;

    // stage 0 adds the leaves and is enabled by valid_in; stage s by vpipe[s-1]
    always_comb begin
        stage_en    = '0;
        stage_en[0] = valid_in;
        for (int s = 1; s < LOG2; s++) stage_en[s] = vpipe[s-1];
    end

    // A node at tree depth d belongs to adder stage LOG2-1-d, so each node
    // only updates when its own input level holds a valid set; this keeps
    // the root stable between valids.
    for (genvar k = 1; k < N_CH; k++) begin : g_en
        assign node_en[k] = stage_en[LOG2 - log2_ceil(k + 1)];
    end

    always_comb begin
        for (int k = 2; k < N_CH; k++) tree[k] = node[k];
        for (int i = 0; i < N_CH; i++)
            tree[N_CH+i] = W_SUM'($signed(data_in[W_IN*i +: W_IN]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpipe <= '0;
            for (int k = 1; k < N_CH; k++) node[k] <= '0;
        end else begin
            vpipe <= stage_en;
            for (int k = 1; k < N_CH; k++)
                if (node_en[k]) node[k] <= tree[2*k] + tree[2*k+1];
        end
    end

    assign sum       = node[1];
    assign valid_out = vpipe[LOG2-1];

endmodule

// File: rtl/lycalo_sum_trig.sv
// Masked channel-sum trigger with consecutive-hit qualification and deadtime.
//   clk, rst    : clock, async active-high reset
//   data        : N_CH packed signed samples; valid_in marks a new set
//   mask        : 1 = channel contributes to sum and OR trigger
//   thr         : signed threshold (sum >= thr and channel >= thr)
//   enable      : 0 holds the FSM in IDLE and suppresses trg
//   qsum        : masked sum, qsum_valid marks a new value
//   trg         : one-cycle sum trigger, busy while in deadtime
//   ortrg       : any unmasked channel >= thr, aligned with qsum_valid
//   trgcount    : saturating count of fired triggers
//
// state   | meaning
// IDLE    | waiting for a valid sum >= thr
// ARM     | cnt consecutive valid sums >= thr seen, fewer than N_CONSEC
// DEAD    | post-fire inhibit, dead_cnt cycles remaining
module lycalo_sum_trig
    import lycalo_sum_trig_pkg::*;
#(
    parameter  int N_CH     = DEF_N_CH,
    parameter  int W_IN     = DEF_W_IN,
    parameter  int N_CONSEC = DEF_N_CONSEC,
    parameter  int DEADTIME = DEF_DEADTIME,
    localparam int LOG2     = log2_ceil(N_CH),
    localparam int W_SUM    = W_IN + LOG2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH*W_IN-1:0]    data,
    input  logic                    valid_in,
    input  logic [N_CH-1:0]         mask,
    input  logic signed [31:0]      thr,
    input  logic                    enable,
    output logic signed [W_SUM-1:0] qsum,
    output logic                    qsum_valid,
    output logic                    trg,
    output logic                    ortrg,
    output logic                    busy,
    output logic [15:0]             trgcount
);

    if (W_SUM > 32) begin : g_chk_wsum
        $error("lycalo_sum_trig: W_IN + log2(N_CH) exceeds 32");
    end
    if (N_CH < 2 || N_CH > 256 || (1 << LOG2) != N_CH) begin : g_chk_nch
        $error("lycalo_sum_trig: N_CH must be a power of two in 2..256");
    end
    if (N_CONSEC < 1 || N_CONSEC > 15) begin : g_chk_consec
        $error("lycalo_sum_trig: N_CONSEC must be in 1..15");
    end
    if (DEADTIME < 0 || DEADTIME > 255) begin : g_chk_dead
        $error("lycalo_sum_trig: DEADTIME must be in 0..255");
    end

    logic [N_CH*W_IN-1:0] samp_d, samp_q;
    logic [N_CH-1:0]      flag_d, flag_q;
    logic                 v0_q;
    logic [LOG2-1:0]      or_pipe;

    always_comb begin
        samp_d = '0;
        flag_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            samp_d[W_IN*i +: W_IN] = mask[i] ? data[W_IN*i +: W_IN] : '0;
            flag_d[i] = mask[i] && (32'($signed(data[W_IN*i +: W_IN])) >= thr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_q  <= '0;
            flag_q  <= '0;
            v0_q    <= 1'b0;
            or_pipe <= '0;
        end else begin
            v0_q    <= valid_in;
            // flags ride a plain shift register that tracks the tree valids
            or_pipe <= LOG2'({or_pipe, |flag_q});
            if (valid_in) begin
                samp_q <= samp_d;
                flag_q <= flag_d;
            end
        end
    end

    lycalo_adder_tree #(
        .N_CH (N_CH),
        .W_IN (W_IN)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .data_in   (samp_q),
        .valid_in  (v0_q),
        .sum       (qsum),
        .valid_out (qsum_valid)
    );

    assign ortrg = or_pipe[LOG2-1] & qsum_valid;

    trig_state_t        state, state_n;
    logic [3:0]         cnt, cnt_n;
    logic [7:0]         dead_cnt, dead_n;
    logic               fire;
    logic signed [31:0] qsum_ext;
    logic               sum_ge;

    assign qsum_ext = 32'(qsum);
    assign sum_ge   = qsum_valid && (qsum_ext >= thr);
    assign busy     = (state == ST_DEAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            dead_cnt <= '0;
            trg      <= 1'b0;
            trgcount <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            dead_cnt <= dead_n;
            trg      <= fire;
            if (fire && trgcount != 16'hFFFF) trgcount <= trgcount + 16'd1;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dead_n  = dead_cnt;
        fire    = 1'b0;
        if (!enable) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            dead_n  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sum_ge) begin
                        cnt_n = 4'd1;
                        if (N_CONSEC == 1) fire = 1'b1;
                        else               state_n = ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (qsum_valid) begin
                        if (sum_ge) begin
                            cnt_n = cnt + 4'd1;
                            if (cnt_n == 4'(N_CONSEC)) fire = 1'b1;
                        end else begin
                            state_n = ST_IDLE;
                            cnt_n   = '0;
                        end
                    end
                end
                ST_DEAD: begin
                    // terminal count: the cycle with dead_cnt==1 is the last inhibited one
                    if (dead_cnt <= 8'd1) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                        dead_n  = '0;
                    end else begin
                        dead_n = dead_cnt - 8'd1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
            if (fire) begin
                cnt_n = '0;
                if (DEADTIME > 0) begin
                    state_n = ST_DEAD;
                    dead_n  = 8'(DEADTIME);
                end else begin
                    state_n = ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_lycalo_sum_trig.sv
module tb_lycalo_sum_trig;

    localparam int N_CH = 16;
    localparam int W_IN = 25;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_CH*W_IN-1:0] data;
    logic                 valid_in;
    logic [N_CH-1:0]      mask;
    logic signed [31:0]   thr;
    logic                 enable;

    logic signed [28:0]   qsum, qsum3;
    logic                 qsum_valid, trg, ortrg, busy;
    logic                 qsum_valid3, trg3, ortrg3, busy3;
    logic [15:0]          trgcount, trgcount3;

    int n_cmp = 0;
    int n_bad = 0;

    lycalo_sum_trig dut (
        .clk(clk), .rst(rst), .data(data), .valid_in(valid_in), .mask(mask),
        .thr(thr), .enable(enable), .qsum(qsum), .qsum_valid(qsum_valid),
        .trg(trg), .ortrg(ortrg), .busy(busy), .trgcount(trgcount)
    );

    lycalo_sum_trig #(.N_CONSEC(3)) dut3 (
        .clk(clk), .rst(rst), .data(data), .valid_in(valid_in), .mask(mask),
        .thr(thr), .enable(enable), .qsum(qsum3), .qsum_valid(qsum_valid3),
        .trg(trg3), .ortrg(ortrg3), .busy(busy3), .trgcount(trgcount3)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input int val);
        logic [31:0] v;
        v = val;
        data[ch*W_IN +: W_IN] = v[W_IN-1:0];
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    // one sample set, wait for its sum, then the trigger cycle, then let deadtime expire
    task automatic run_sample(output logic signed [31:0] q, output logic o,
                              output logic t_at, output logic t, output int lat);
        lat = -1; q = '0; o = 1'b0; t = 1'b0; t_at = 1'b0;
        valid_in = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            valid_in = 1'b0;
            if (qsum_valid === 1'b1) begin
                lat = i; q = qsum; o = ortrg; t_at = trg;
                break;
            end
        end
        step();
        t = trg;
        repeat (12) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_in = 1'b0; data = '0; mask = '1; thr = '0; enable = 1'b1;
        step(); step();
        n_cmp++; if (qsum !== 29'sd0) begin n_bad++; $display("FAIL reset_qsum: got %0d expected 0", qsum); end
        n_cmp++; if (qsum_valid !== 1'b0) begin n_bad++; $display("FAIL reset_qsum_valid: got %b expected 0", qsum_valid); end
        n_cmp++; if (trg !== 1'b0) begin n_bad++; $display("FAIL reset_trg: got %b expected 0", trg); end
        n_cmp++; if (ortrg !== 1'b0) begin n_bad++; $display("FAIL reset_ortrg: got %b expected 0", ortrg); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (trgcount !== 16'd0) begin n_bad++; $display("FAIL reset_trgcount: got %0d expected 0", trgcount); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic signed [31:0] q; logic o, ta, t; int lat;
        do_reset();
        data = '0; mask = '1; thr = 0;
        set_ch(0, 10); set_ch(1, 20); set_ch(2, 30); set_ch(3, 40);
        run_sample(q, o, ta, t, lat);
        n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL basic_latency: got %0d expected 5", lat); end
        n_cmp++; if (q !== 100) begin n_bad++; $display("FAIL basic_qsum: got %0d expected 100", q); end
        n_cmp++; if (o !== 1'b1) begin n_bad++; $display("FAIL basic_ortrg: got %b expected 1", o); end
        n_cmp++; if (ta !== 1'b0) begin n_bad++; $display("FAIL basic_trg_early: got %b expected 0", ta); end
        n_cmp++; if (t !== 1'b1) begin n_bad++; $display("FAIL basic_trg: got %b expected 1", t); end
        n_cmp++; if (trgcount !== 16'd1) begin n_bad++; $display("FAIL basic_trgcount1: got %0d expected 1", trgcount); end
        set_ch(4, -10);
        run_sample(q, o, ta, t, lat);
        n_cmp++; if (q !== 90) begin n_bad++; $display("FAIL basic_qsum_neg: got %0d expected 90", q); end
        n_cmp++; if (t !== 1'b1) begin n_bad++; $display("FAIL basic_trg2: got %b expected 1", t); end
        n_cmp++; if (trgcount !== 16'd2) begin n_bad++; $display("FAIL basic_trgcount2: got %0d expected 2", trgcount); end
    endtask

    task automatic test_equality();
        logic signed [31:0] q; logic o, ta, t; int lat;
        data = '0; mask = 16'h0001; set_ch(0, -100);
        thr = -101;
        run_sample(q, o, ta, t, lat);
        n_cmp++; if (q !== -100) begin n_bad++; $display("FAIL eq_qsum: got %0d expected -100", q); end
        n_cmp++; if (t !== 1'b1) begin n_bad++; $display("FAIL eq_trg_below: got %b expected 1", t); end
        thr = -100;
        run_sample(q, o, ta, t, lat);
        n_cmp++; if (t !== 1'b1) begin n_bad++; $display("FAIL eq_trg_equal: got %b expected 1", t); end
        n_cmp++; if (o !== 1'b1) begin n_bad++; $display("FAIL eq_ortrg_equal: got %b expected 1", o); end
        thr = -99;
        run_sample(q, o, ta, t, lat);
        n_cmp++; if (t !== 1'b0) begin n_bad++; $display("FAIL eq_trg_above: got %b expected 0", t); end
        n_cmp++; if (o !== 1'b0) begin n_bad++; $display("FAIL eq_ortrg_above: got %b expected 0", o); end
    endtask

    task automatic test_mask();
        logic signed [31:0] q; logic o, ta, t; int lat;
        data = '0; set_ch(1, 1000); thr = 500;
        mask = 16'hFFFD;
        run_sample(q, o, ta, t, lat);
        n_cmp++; if (q !== 0) begin n_bad++; $display("FAIL mask_off_qsum: got %0d expected 0", q); end
        n_cmp++; if (o !== 1'b0) begin n_bad++; $display("FAIL mask_off_ortrg: got %b expected 0", o); end
        n_cmp++; if (t !== 1'b0) begin n_bad++; $display("FAIL mask_off_trg: got %b expected 0", t); end
        mask = 16'hFFFF;
        run_sample(q, o, ta, t, lat);
        n_cmp++; if (q !== 1000) begin n_bad++; $display("FAIL mask_on_qsum: got %0d expected 1000", q); end
        n_cmp++; if (o !== 1'b1) begin n_bad++; $display("FAIL mask_on_ortrg: got %b expected 1", o); end
        n_cmp++; if (t !== 1'b1) begin n_bad++; $display("FAIL mask_on_trg: got %b expected 1", t); end
    endtask

    task automatic test_extremes();
        logic signed [31:0] q; logic o, ta, t; int lat;
        mask = '1; thr = 0;
        for (int i = 0; i < N_CH; i++) set_ch(i, 16777215);
        run_sample(q, o, ta, t, lat);
        n_cmp++; if (q !== 268435440) begin n_bad++; $display("FAIL ext_max_qsum: got %0d expected 268435440", q); end
        for (int i = 0; i < N_CH; i++) set_ch(i, -16777216);
        run_sample(q, o, ta, t, lat);
        n_cmp++; if (q !== -268435456) begin n_bad++; $display("FAIL ext_min_qsum: got %0d expected -268435456", q); end
        n_cmp++; if (t !== 1'b0) begin n_bad++; $display("FAIL ext_min_trg: got %b expected 0", t); end
    endtask

    task automatic test_back_to_back();
        int first, second, nbusy;
        first = -1; second = -1; nbusy = 0;
        data = '0; set_ch(0, 5); mask = '1; thr = 0;
        valid_in = 1'b1;
        for (int i = 1; i <= 26; i++) begin
            step();
            if (trg === 1'b1) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            if (i <= 14 && busy === 1'b1) nbusy++;
        end
        valid_in = 1'b0;
        repeat (15) step();
        n_cmp++; if (first != 6) begin n_bad++; $display("FAIL b2b_first_trg: got cycle %0d expected 6", first); end
        n_cmp++; if (second != 15) begin n_bad++; $display("FAIL b2b_second_trg: got cycle %0d expected 15", second); end
        n_cmp++; if (nbusy != 8) begin n_bad++; $display("FAIL b2b_busy_cycles: got %0d expected 8", nbusy); end
    endtask

    task automatic test_enable();
        int ntrg_off;
        ntrg_off = 0;
        do_reset();
        data = '0; set_ch(0, 5); mask = '1; thr = 0; enable = 1'b1;
        valid_in = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            step();
            if (i == 6) begin
                n_cmp++; if (trg !== 1'b1) begin n_bad++; $display("FAIL en_first_trg: got %b expected 1", trg); end
            end
            if (i == 8) begin
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL en_busy_before: got %b expected 1", busy); end
                enable = 1'b0;
            end
            if (i == 9) begin
                n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL en_busy_cleared: got %b expected 0", busy); end
                n_cmp++; if (trgcount !== 16'd1) begin n_bad++; $display("FAIL en_trgcount_kept: got %0d expected 1", trgcount); end
            end
            if (i >= 9 && i <= 12 && trg === 1'b1) ntrg_off++;
            if (i == 10) begin
                n_cmp++; if (ortrg !== 1'b1) begin n_bad++; $display("FAIL en_ortrg_disabled: got %b expected 1", ortrg); end
            end
            if (i == 12) enable = 1'b1;
            if (i == 13) begin
                n_cmp++; if (trg !== 1'b1) begin n_bad++; $display("FAIL en_reenable_trg: got %b expected 1", trg); end
                n_cmp++; if (trgcount !== 16'd2) begin n_bad++; $display("FAIL en_trgcount: got %0d expected 2", trgcount); end
            end
        end
        valid_in = 1'b0;
        repeat (15) step();
        n_cmp++; if (ntrg_off != 0) begin n_bad++; $display("FAIL en_trg_while_off: got %0d pulses expected 0", ntrg_off); end
    endtask

    task automatic test_consec();
        int vals [6];
        int n3, first3;
        logic t1;
        vals = '{5, 5, -5, 5, 5, 5};
        n3 = 0; first3 = -1; t1 = 1'b0;
        do_reset();
        data = '0; mask = '1; thr = 0; enable = 1'b1;
        set_ch(0, vals[0]);
        valid_in = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i < 6) set_ch(0, vals[i]);
            else valid_in = 1'b0;
            if (trg3 === 1'b1) begin
                n3++;
                if (first3 < 0) first3 = i;
            end
            if (i == 6) t1 = trg;
        end
        repeat (5) step();
        n_cmp++; if (n3 != 1) begin n_bad++; $display("FAIL consec_trg_count: got %0d expected 1", n3); end
        n_cmp++; if (first3 != 11) begin n_bad++; $display("FAIL consec_trg_cycle: got %0d expected 11", first3); end
        n_cmp++; if (t1 !== 1'b1) begin n_bad++; $display("FAIL consec_single_dut_trg: got %b expected 1", t1); end
    endtask

    task automatic test_rst_mid();
        int nv, nt;
        nv = 0; nt = 0;
        data = '0; set_ch(0, 10); mask = '1; thr = 0; enable = 1'b1;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        step();
        rst = 1'b1;
        #1;
        n_cmp++; if (qsum !== 29'sd0) begin n_bad++; $display("FAIL rst_mid_qsum: got %0d expected 0", qsum); end
        n_cmp++; if (qsum_valid !== 1'b0 || trg !== 1'b0 || ortrg !== 1'b0 || busy !== 1'b0)
            begin n_bad++; $display("FAIL rst_mid_flags: got v=%b t=%b o=%b b=%b expected all 0", qsum_valid, trg, ortrg, busy); end
        n_cmp++; if (trgcount !== 16'd0) begin n_bad++; $display("FAIL rst_mid_trgcount: got %0d expected 0", trgcount); end
        step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (qsum_valid === 1'b1) nv++;
            if (trg === 1'b1) nt++;
        end
        n_cmp++; if (nv != 0) begin n_bad++; $display("FAIL rst_mid_no_valid: got %0d expected 0", nv); end
        n_cmp++; if (nt != 0) begin n_bad++; $display("FAIL rst_mid_no_trg: got %0d expected 0", nt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_equality();
        test_mask();
        test_extremes();
        test_back_to_back();
        test_enable();
        test_consec();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lycalo_sum_trig.md
LYCALO_SUM_TRIG -- requirements
Module: lycalo_sum_trig

Interface
REQ-001 SHALL have parameter N_CH, default 16: number of input channels; power of two, 2..256.
REQ-002 SHALL have parameter W_IN, default 25: signed sample width per channel.
REQ-003 SHALL have parameter N_CONSEC, default 1: consecutive over-threshold sums needed to fire, 1..15.
REQ-004 SHALL have parameter DEADTIME, default 8: cycles of trigger inhibit after a fire, 0..255.
REQ-005 SHALL derive W_SUM = W_IN + log2(N_CH); W_SUM <= 32 SHALL be checked at elaboration.
REQ-006 SHALL have one clock; reset is asynchronous and active-high.
REQ-007 CLK  in  1  sole clock; all state changes on rising edge.
REQ-008 RST  in  1  asynchronous active-high reset.
REQ-009 DATA  in  N_CH*W_IN  packed signed samples; channel i at bits [W_IN*i +: W_IN].
REQ-010 VALID_IN  in  1  DATA holds a new sample set this cycle.
REQ-011 MASK  in  N_CH  1 = channel included in sum and OR trigger.
REQ-012 THR  in  32  signed threshold.
REQ-013 ENABLE  in  1  0 = TRG suppressed and FSM held in IDLE.
REQ-014 QSUM  out  W_SUM  signed masked sum.
REQ-015 QSUM_VALID  out  1  QSUM is new this cycle.
REQ-016 TRG  out  1  one-cycle sum-trigger pulse.
REQ-017 ORTRG  out  1  any unmasked channel >= THR, aligned with QSUM_VALID.
REQ-018 BUSY  out  1  FSM in DEAD.
REQ-019 TRGCOUNT  out  16  fired-trigger count, saturating at 0xFFFF.

Function
REQ-020 Stage 0 SHALL register each sample, forcing masked channels to 0, and register per-channel (sample >= THR) AND MASK, when VALID_IN=1.
REQ-021 Adder tree SHALL be fully pipelined: log2(N_CH) registered pairwise stages, sign-extended at each stage; accepts one sample set per cycle.
REQ-022 QSUM/QSUM_VALID SHALL appear exactly L = log2(N_CH)+1 cycles after the VALID_IN cycle; valid SHALL propagate with data; QSUM holds between valids.
REQ-023 Sum arithmetic SHALL be exact (no overflow possible by width rule); no saturation.
REQ-024 Comparisons SHALL be signed, QSUM sign-extended to 32 bits; condition is QSUM >= THR (equality fires).
REQ-025 ORTRG SHALL be the OR of stage-0 channel flags, delayed to coincide with QSUM_VALID; 0 when QSUM_VALID=0; unaffected by ENABLE or deadtime.
REQ-026 FSM states IDLE, ARM, DEAD; CNT counts consecutive over-threshold valid sums.
REQ-027 IDLE: on valid sum >= THR with ENABLE, CNT=1; if N_CONSEC=1 fire, else go ARM.
REQ-028 ARM: valid sum >= THR increments CNT, fires when CNT reaches N_CONSEC; valid sum < THR returns to IDLE with CNT=0; cycles without valid leave state unchanged.
REQ-029 Fire SHALL assert TRG for one cycle, registered, the cycle after the qualifying QSUM_VALID; increment TRGCOUNT; enter DEAD if DEADTIME>0, else IDLE.
REQ-030 DEAD SHALL last exactly DEADTIME cycles, ignoring all sums, then go IDLE with CNT=0.
REQ-031 ENABLE=0 SHALL force IDLE, CNT=0 within one cycle, including from ARM and DEAD; TRGCOUNT retained.
REQ-032 THR and MASK changes SHALL take effect on the next VALID_IN sample; in-flight samples keep the values captured at stage 0 (mask) and the THR at comparison.

Reset
REQ-033 RST SHALL clear all pipeline data and valids, FSM to IDLE, CNT, TRGCOUNT; outputs QSUM=0, QSUM_VALID=0, TRG=0, ORTRG=0, BUSY=0.
REQ-034 RST mid-pipeline SHALL discard in-flight samples; no TRG or QSUM_VALID for them after release.

Structure
REQ-035 Shared package SHALL hold the FSM state enum, default parameter constants, and a log2 helper.
REQ-036 Adder tree SHALL be a sub-module lycalo_adder_tree (parametrised N_CH, W_IN, carries valid).

Verification (N_CH=16, W_IN=25, N_CONSEC=1, DEADTIME=8 unless stated)
REQ-037 Ch0..3=10,20,30,40, others 0, MASK all 1, THR=0 -> QSUM=100 at L=5, TRG pulse one cycle later; add ch4=-10 -> QSUM=90.
REQ-038 Ch0=-100, THR=-101 then THR=-100 -> TRG both cases (equality fires); THR=-99 -> no TRG, ORTRG=0.
REQ-039 MASK bit1=0 with ch1=1000, others 0, THR=500 -> QSUM=0, ORTRG=0, no TRG; MASK bit1=1 -> QSUM=1000, ORTRG=1, TRG.
REQ-040 Continuous over-threshold sums every cycle -> TRG at cycle k, next at k+9, BUSY high 8 cycles; N_CONSEC=3 with sums over,over,under,over,over,over -> single TRG after the sixth.
REQ-041 All channels 2^24-1 -> QSUM=16*(2^24-1) exact; all -2^24 -> QSUM=-2^28.
REQ-042 RST asserted 2 cycles after VALID_IN -> all outputs 0 immediately, no QSUM_VALID/TRG afterwards, TRGCOUNT=0.
